// File: rtl/score_tracker_param.sv
// Score tracker: game FSM (PLAY/OVER) with high score and sequential BCD display.
// Ports: clk, rst, goodColl, badColl, restart in; current_score, high_score, dispScore, bcd, bcd_valid, isGameComplete out.
module score_tracker_param #(
  parameter int SCORE_W   = 8,
  parameter int MAX_SCORE = 50,
  parameter int DIGITS    = 3,
  parameter int GOOD_PTS  = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  goodColl,
  input  logic                  badColl,
  input  logic                  restart,
  output logic [SCORE_W-1:0]    current_score,
  output logic [SCORE_W-1:0]    high_score,
  output logic [SCORE_W-1:0]    dispScore,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  bcd_valid,
  output logic                  isGameComplete
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(SCORE_W + 1);

  function automatic longint pow10(input int n);
    longint r;
    r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

  localparam longint SPAN = longint'(1) << SCORE_W;

  generate
    if (!(GOOD_PTS >= 1 && GOOD_PTS <= MAX_SCORE &&
          longint'(MAX_SCORE) < SPAN &&
          SPAN - 1 <= pow10(DIGITS) - 1)) begin : g_param_err
      $error("score_tracker_param: illegal parameter set");
    end
  endgenerate

  localparam logic [SCORE_W:0]   PTS  = (SCORE_W + 1)'(GOOD_PTS);
  localparam logic [SCORE_W:0]   MAXW = (SCORE_W + 1)'(MAX_SCORE);
  localparam logic [SCORE_W-1:0] MAXV = SCORE_W'(MAX_SCORE);
  localparam logic [CW-1:0]      LAST = CW'(SCORE_W - 1);

  typedef enum logic {PLAY, OVER} game_e;
  typedef enum logic {IDLE, SHIFT} bcd_e;

  // ---------------- game FSM ----------------
  game_e              game_q;
  logic [SCORE_W-1:0] cur_q;
  logic [SCORE_W-1:0] hi_q;
  logic               gprev_q;

  logic               good_edge;
  logic [SCORE_W:0]   sum_d;
  logic [SCORE_W-1:0] score_d;

  assign good_edge = goodColl & ~gprev_q;
  // One extra bit so the sum saturates instead of wrapping.
  assign sum_d     = {1'b0, cur_q} + PTS;
  assign score_d   = (sum_d >= MAXW) ? MAXV : sum_d[SCORE_W-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      game_q  <= PLAY;
      cur_q   <= '0;
      hi_q    <= '0;
      // Held high so a level present across reset release is not an edge.
      gprev_q <= 1'b1;
    end else begin
      gprev_q <= goodColl;
      if (restart) begin
        cur_q  <= '0;
        game_q <= PLAY;
      end else if (game_q == PLAY) begin
        if (badColl) begin
          game_q <= OVER;
        end else if (good_edge) begin
          cur_q <= score_d;
          if (score_d == MAXV) game_q <= OVER;
          if (score_d > hi_q) hi_q <= score_d;
        end
      end
    end
  end

  assign current_score  = cur_q;
  assign high_score     = hi_q;
  assign isGameComplete = (game_q == OVER);
  assign dispScore      = (game_q == PLAY) ? cur_q : hi_q;

  // ---------------- BCD converter ----------------
  bcd_e               bst_q;
  logic [SCORE_W-1:0] src_q;
  logic [SCORE_W-1:0] sh_q;
  logic [BW-1:0]      acc_q;
  logic [BW-1:0]      acc_d;
  logic [BW-1:0]      bcd_q;
  logic [CW-1:0]      cnt_q;
  logic               valid_q;

  // One double-dabble step: add-3 correction then shift in next bit.
  function automatic logic [BW-1:0] dd_step(input logic [BW-1:0] a,
                                            input logic b);
    logic [BW-1:0] t;
    t = a;
    for (int i = 0; i < DIGITS; i++) begin
      if (t[4*i +: 4] >= 4'd5) t[4*i +: 4] = t[4*i +: 4] + 4'd3;
    end
    return {t[BW-2:0], b};
  endfunction

  assign acc_d = dd_step(acc_q, sh_q[SCORE_W-1]);

  always_ff @(posedge clk) begin
    if (rst) begin
      bst_q   <= IDLE;
      src_q   <= '0;
      sh_q    <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      bcd_q   <= '0;
      valid_q <= 1'b1;
    end else begin
      unique case (bst_q)
        IDLE: begin
          if (dispScore != src_q) begin
            src_q   <= dispScore;
            sh_q    <= dispScore;
            acc_q   <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            bst_q   <= SHIFT;
          end
        end
        SHIFT: begin
          acc_q <= acc_d;
          sh_q  <= sh_q << 1;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            bcd_q <= acc_d;
            // Stay low if the source moved mid-conversion; a
            // reconversion follows on the next IDLE cycle.
            valid_q <= (dispScore == src_q);
            bst_q   <= IDLE;
          end
        end
        default: bst_q <= IDLE;
      endcase
    end
  end

  assign bcd       = bcd_q;
  assign bcd_valid = valid_q;

endmodule

// File: tb/tb_score_tracker_param.sv
// Directed bench for score_tracker_param (default and wide parameter sets).
// Immediate assertions at each check; one summary line at the end.
module tb_score_tracker_param;

  logic clk = 1'b0;
  logic rst, goodColl, badColl, restart;
  logic [7:0]  cur, hi, disp;
  logic [11:0] bcd;
  logic        vld, done;

  logic        g2;
  logic [9:0]  cur2, hi2, disp2;
  logic [15:0] bcd2;
  logic        vld2, done2;

  int checks = 0;
  int errors = 0;
  logic saw;

  always #5 clk = ~clk;

  score_tracker_param dut (
    .clk(clk), .rst(rst), .goodColl(goodColl), .badColl(badColl),
    .restart(restart), .current_score(cur), .high_score(hi),
    .dispScore(disp), .bcd(bcd), .bcd_valid(vld),
    .isGameComplete(done)
  );

  score_tracker_param #(
    .SCORE_W(10), .MAX_SCORE(999), .DIGITS(4), .GOOD_PTS(7)
  ) dut2 (
    .clk(clk), .rst(rst), .goodColl(g2), .badColl(1'b0),
    .restart(1'b0), .current_score(cur2), .high_score(hi2),
    .dispScore(disp2), .bcd(bcd2), .bcd_valid(vld2),
    .isGameComplete(done2)
  );

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse(input int n = 1);
    repeat (n) begin
      goodColl = 1'b1; tick();
      goodColl = 1'b0; tick();
    end
  endtask

  task automatic pulse2(input int n = 1);
    repeat (n) begin
      g2 = 1'b1; tick();
      g2 = 1'b0; tick();
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; goodColl = 1'b0; badColl = 1'b0;
    restart = 1'b0; g2 = 1'b0;
    tick();
    rst = 1'b0;
    chk("rst_cur", cur, 0);
    chk("rst_hi", hi, 0);
    chk("rst_bcd", bcd, 0);
    chk("rst_vld", vld, 1);
    chk("rst_done", done, 0);
    tick(2);

    // three pulses, exact latency on the third
    pulse(2);
    tick(20);
    chk("p2_bcd", bcd, 12'h002);
    pulse();
    tick(7);
    chk("lat_vld_lo", vld, 0);
    chk("lat_bcd_hold", bcd, 12'h002);
    tick();
    chk("lat_vld_hi", vld, 1);
    chk("p3_bcd", bcd, 12'h003);
    chk("p3_cur", cur, 3);
    chk("p3_hi", hi, 3);

    // held level scores once
    goodColl = 1'b1; tick(10);
    goodColl = 1'b0; tick();
    chk("held_cur", cur, 4);

    // level across reset release
    goodColl = 1'b1; rst = 1'b1; tick();
    rst = 1'b0; tick(3);
    chk("rstrel_cur", cur, 0);
    chk("rstrel_hi", hi, 0);
    goodColl = 1'b0; tick();
    pulse();
    chk("after_rel", cur, 1);

    // run to MAX_SCORE
    pulse(48);
    chk("cur49", cur, 49);
    chk("done49", done, 0);
    goodColl = 1'b1; tick();
    chk("cur50", cur, 50);
    chk("done50", done, 1);
    goodColl = 1'b0; tick();
    pulse(3);
    chk("over_hold", cur, 50);
    tick(20);
    chk("bcd50", bcd, 12'h050);
    chk("vld50", vld, 1);
    chk("disp50", disp, 50);

    // good+bad same cycle, OVER shows high score
    restart = 1'b1; tick();
    restart = 1'b0;
    chk("rs_cur", cur, 0);
    chk("rs_hi", hi, 50);
    chk("rs_done", done, 0);
    pulse(7);
    chk("cur7", cur, 7);
    goodColl = 1'b1; badColl = 1'b1; tick();
    goodColl = 1'b0; badColl = 1'b0;
    chk("gb_cur", cur, 7);
    chk("gb_done", done, 1);
    chk("gb_disp", disp, 50);
    tick();
    pulse();
    chk("over_ign", cur, 7);
    restart = 1'b1; tick();
    restart = 1'b0; tick();
    chk("rs2_cur", cur, 0);
    chk("rs2_hi", hi, 50);
    chk("rs2_disp", disp, 0);

    // restart beats a good edge in PLAY
    pulse();
    restart = 1'b1; goodColl = 1'b1; tick();
    restart = 1'b0; goodColl = 1'b0; tick();
    chk("rs_prio", cur, 0);

    // high score never decreases
    rst = 1'b1; tick();
    rst = 1'b0; tick();
    pulse(2);
    chk("hi2", hi, 2);
    badColl = 1'b1; tick();
    badColl = 1'b0;
    chk("bad_done", done, 1);
    restart = 1'b1; tick();
    restart = 1'b0; tick();
    pulse();
    chk("hi_keep", hi, 2);
    chk("cur1", cur, 1);

    // change during SHIFT
    tick(20);
    saw = 1'b0;
    pulse();
    saw |= vld;
    repeat (2) begin tick(); saw |= vld; end
    pulse();
    saw |= vld;
    repeat (12) begin tick(); saw |= vld; end
    chk("mid_vld_lo", saw, 0);
    tick();
    chk("mid_vld_hi", vld, 1);
    chk("mid_bcd", bcd, 12'h003);

    // plain bad collision, then reset in OVER
    badColl = 1'b1; tick();
    badColl = 1'b0;
    chk("bad_cur", cur, 3);
    chk("bad_over", done, 1);
    rst = 1'b1; tick();
    rst = 1'b0;
    chk("rst2_done", done, 0);
    chk("rst2_hi", hi, 0);
    chk("rst2_bcd", bcd, 0);
    chk("rst2_vld", vld, 1);
    tick();

    // wide parameter set
    pulse2(142);
    chk("w_cur994", cur2, 994);
    chk("w_done0", done2, 0);
    pulse2();
    chk("w_cur999", cur2, 999);
    chk("w_done1", done2, 1);
    tick(25);
    chk("w_bcd", bcd2, 16'h0999);
    chk("w_vld", vld2, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
